// File: rtl/pms_spi_slave.sv
// pms_spi_slave: SPI mode 0 slave (CPOL=0, CPHA=0), MSB first, 8-bit frames.
//
// All SPI pins are asynchronous to clk_i. Each pin goes through SYNC_STAGES
// flops. Every state change is driven by one-cycle edge strobes taken from
// the synchronized copies of the pins.
//
// Parameters
//   SYNC_STAGES   synchronizer depth per SPI input (2..4)
//   RX_FIFO_DEPTH RX FIFO entries, power of two >= 2 (FIFO build only)
//
// Build option
//   PMS_SPI_SLV_RX_FIFO_EN  defined:   RX storage is an RX_FIFO_DEPTH-entry FIFO
//                           undefined: RX storage is a single holding register
//
// Ports
//   clk_i, rst_i           system clock, synchronous active-high reset
//   spi_sclk_i/csn_i/mosi_i SPI inputs from the external master (async)
//   spi_miso_o, spi_miso_oe_o  slave data out and its output enable
//   tx_data_i/valid_i/ready_o  next byte to transmit (ready only on load event)
//   rx_data_o/valid_o/ready_i  received bytes, oldest first
//   overflow_o             RX byte dropped because storage was full
//   underrun_o             load event found no TX byte; 0xFF sent instead
//   abort_o                CS released in the middle of a byte

module pms_spi_slave #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_sclk_i,
  input  logic       spi_csn_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       overflow_o,
  output logic       underrun_o,
  output logic       abort_o
);

`ifdef PMS_SPI_SLV_RX_FIFO_EN
  localparam bit FifoEn = 1'b1;
`else
  localparam bit FifoEn = 1'b0;
`endif

  // Elaboration-time parameter legality checks.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : gen_bad_sync_stages
    $error("pms_spi_slave: SYNC_STAGES must be in 2..4");
  end
  if (FifoEn && (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0))
  begin : gen_bad_fifo_depth
    $error("pms_spi_slave: RX_FIFO_DEPTH must be a power of two >= 2");
  end

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, csn_prev_q;
  logic                   sclk_s, csn_s, mosi_s;
  logic                   sclk_rise, sclk_fall, csn_rise, csn_fall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign csn_rise  = csn_s & ~csn_prev_q;
  assign csn_fall  = ~csn_s & csn_prev_q;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e     state_q, state_d;
  logic [7:0] tx_sr_q;
  logic [6:0] rx_sr_q;     // first seven bits; the eighth comes straight from mosi_s
  logic [2:0] bit_cnt_q;
  logic       byte_end_q;  // 8th rise seen, next sclk fall is a load event
  logic       push_q;
  logic [7:0] push_data_q;

  logic load_evt, shift_evt, rx_shift, leave_evt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // A csn rise wins over a coincident sclk edge, so a master that drops SCLK
  // and raises CS together does not trigger a spare load at the frame end.
  always_comb begin
    state_d   = state_q;
    load_evt  = 1'b0;
    shift_evt = 1'b0;
    rx_shift  = 1'b0;
    leave_evt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (csn_fall) begin
          state_d  = StActive;
          load_evt = 1'b1;
        end
      end
      StActive: begin
        if (csn_rise) begin
          state_d   = StIdle;
          leave_evt = 1'b1;
        end else begin
          rx_shift = sclk_rise;
          if (sclk_fall) begin
            load_evt  = byte_end_q;
            shift_evt = ~byte_end_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift registers and bit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_sr_q     <= 8'h00;
      rx_sr_q     <= 7'h00;
      bit_cnt_q   <= 3'd0;
      byte_end_q  <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= 8'h00;
    end else begin
      if (load_evt) begin
        tx_sr_q <= tx_valid_i ? tx_data_i : 8'hFF;
      end else if (shift_evt) begin
        tx_sr_q <= {tx_sr_q[6:0], 1'b0};
      end

      push_q <= rx_shift && (bit_cnt_q == 3'd7);
      if (rx_shift && (bit_cnt_q == 3'd7)) begin
        push_data_q <= {rx_sr_q, mosi_s};
      end

      if (leave_evt) begin
        // Partial byte is discarded on CS release.
        rx_sr_q    <= 7'h00;
        bit_cnt_q  <= 3'd0;
        byte_end_q <= 1'b0;
      end else if (rx_shift) begin
        rx_sr_q    <= {rx_sr_q[5:0], mosi_s};
        bit_cnt_q  <= bit_cnt_q + 3'd1;
        byte_end_q <= (bit_cnt_q == 3'd7);
      end else if (load_evt || shift_evt) begin
        byte_end_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RX storage
  // ---------------------------------------------------------------------------
  logic rx_pop, rx_full, push_ok;

  assign rx_pop  = rx_valid_o & rx_ready_i;
  // A pop in the push cycle frees a slot, so a full store still accepts the byte.
  assign push_ok = push_q & (~rx_full | rx_pop);

`ifdef PMS_SPI_SLV_RX_FIFO_EN
  localparam int unsigned PtrW = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(RX_FIFO_DEPTH);

  logic [7:0]      mem_q [RX_FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   cnt_q;

  assign rx_full = (cnt_q == FullCnt);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rx_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_ok && !rx_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!push_ok && rx_pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Storage array needs no reset; rx_data_o is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_q;
    end
  end

  assign rx_valid_o = (cnt_q != '0);
  assign rx_data_o  = rx_valid_o ? mem_q[rd_ptr_q] : 8'h00;
`else
  logic [7:0] hold_q;
  logic       hold_valid_q;

  assign rx_full = hold_valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
    end else if (push_ok) begin
      hold_q       <= push_data_q;
      hold_valid_q <= 1'b1;
    end else if (rx_pop) begin
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
    end
  end

  assign rx_valid_o = hold_valid_q;
  assign rx_data_o  = hold_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign spi_miso_oe_o = (state_q == StActive);
  assign spi_miso_o    = (state_q == StActive) & tx_sr_q[7];
  assign tx_ready_o    = load_evt;
  assign underrun_o    = load_evt & ~tx_valid_i;
  assign overflow_o    = push_q & rx_full & ~rx_pop;
  assign abort_o       = leave_evt & (bit_cnt_q != 3'd0);

endmodule

// File: tb/tb_pms_spi_slave.sv
// Self-checking bench for pms_spi_slave. A queue-based model holds the bytes
// the master has sent (capped at the storage depth); a compare process checks
// every RX output cycle against it and counts event pulses.

module tb_pms_spi_slave;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned FifoDepth  = 4;
  localparam int          Half       = 6;   // clk_i cycles per SCLK phase
`ifdef PMS_SPI_SLV_RX_FIFO_EN
  localparam int          Cap        = FifoDepth;
  localparam int          OvfLit     = 1;
  localparam int          PopLit     = 4;
`else
  localparam int          Cap        = 1;
  localparam int          OvfLit     = 4;
  localparam int          PopLit     = 1;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       spi_sclk_i = 1'b0;
  logic       spi_csn_i = 1'b1;
  logic       spi_mosi_i = 1'b0;
  logic       spi_miso_o, spi_miso_oe_o;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i = 1'b0;
  logic       overflow_o, underrun_o, abort_o;

  pms_spi_slave #(
    .SYNC_STAGES  (SyncStages),
    .RX_FIFO_DEPTH(FifoDepth)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .spi_sclk_i   (spi_sclk_i),
    .spi_csn_i    (spi_csn_i),
    .spi_mosi_i   (spi_mosi_i),
    .spi_miso_o   (spi_miso_o),
    .spi_miso_oe_o(spi_miso_oe_o),
    .tx_data_i    (tx_data_i),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .overflow_o   (overflow_o),
    .underrun_o   (underrun_o),
    .abort_o      (abort_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Model state
  logic [7:0] exp_q[$];
  int         exp_und = 0, exp_ovf = 0, exp_abt = 0;
  int         cnt_und = 0, cnt_ovf = 0, cnt_abt = 0, cnt_pop = 0;
  logic [7:0] tx_stream [128];
  int         sp = 0;        // model's TX stream position
  int         tx_idx = 0;    // driver's TX stream position
  logic       rx_rand = 1'b0;
  logic       rx_ready_fixed = 1'b0;

  // Frame description consumed by run_frame
  logic [7:0] fr_bytes [16];
  int         fr_n;
  int         fr_last_bits;
  bit         fr_hold;
  logic [7:0] miso_log [16];

  // TX source: advances one stream entry per accepted handshake.
  initial begin
    logic hs;
    forever begin
      @(negedge clk_i);
      hs = tx_ready_o && tx_valid_i;
      @(posedge clk_i);
      #1;
      if (hs) tx_idx++;
      tx_data_i = tx_stream[tx_idx % 128];
    end
  end

  // RX sink ready: fixed or random.
  initial forever begin
    @(posedge clk_i);
    #1;
    rx_ready_i = rx_rand ? 1'($urandom_range(0, 1)) : rx_ready_fixed;
  end

  // Compare process: every out-of-reset cycle.
  initial forever begin
    @(negedge clk_i);
    if (!rst_i) begin
      if (overflow_o) cnt_ovf++;
      if (underrun_o) cnt_und++;
      if (abort_o)    cnt_abt++;
      if (!spi_miso_oe_o) check("miso_low_when_disabled", {31'd0, spi_miso_o}, 32'd0);
      if (exp_q.size() == 0) begin
        check("rx_valid_with_empty_model", {31'd0, rx_valid_o}, 32'd0);
      end else if (rx_valid_o) begin
        check("rx_data_vs_model", {24'd0, rx_data_o}, {24'd0, exp_q[0]});
        if (rx_ready_i) begin
          void'(exp_q.pop_front());
          cnt_pop++;
        end
      end
    end
  end

  task automatic run_frame();
    logic [7:0] got, e, mask;
    int nb;
    spi_csn_i = 1'b0;
    wait_cyc(Half);
    for (int b = 0; b < fr_n; b++) begin
      nb = (b == fr_n - 1) ? fr_last_bits : 8;
      if (tx_valid_i) begin
        e = tx_stream[sp];
        sp++;
      end else begin
        e = 8'hFF;
        exp_und++;
      end
      got = 8'h00;
      for (int i = 0; i < nb; i++) begin
        spi_mosi_i = fr_bytes[b][7-i];
        wait_cyc(Half);
        got[7-i] = spi_miso_o;
        if (i == 0) check("miso_oe_in_frame", {31'd0, spi_miso_oe_o}, 32'd1);
        spi_sclk_i = 1'b1;
        if (i == 7) begin
          if (exp_q.size() < Cap) exp_q.push_back(fr_bytes[b]);
          else exp_ovf++;
        end
        wait_cyc(Half);
        spi_sclk_i = 1'b0;
        if (b == fr_n - 1 && i == nb - 1 && !fr_hold) spi_csn_i = 1'b1;
      end
      mask = 8'hFF << (8 - nb);
      miso_log[b] = got;
      check("miso_byte", {24'd0, got & mask}, {24'd0, e & mask});
    end
    if (!fr_hold) begin
      if (fr_last_bits != 8) exp_abt++;
      wait_cyc(3 * Half);
      check("miso_oe_after_frame", {31'd0, spi_miso_oe_o}, 32'd0);
    end
  endtask

  task automatic check_counts();
    check("overflow_count", cnt_ovf, exp_ovf);
    check("underrun_count", cnt_und, exp_und);
    check("abort_count", cnt_abt, exp_abt);
  endtask

  task automatic check_reset_outputs();
    check("rst_miso", {31'd0, spi_miso_o}, 32'd0);
    check("rst_miso_oe", {31'd0, spi_miso_oe_o}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready_o}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid_o}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data_o}, 32'd0);
    check("rst_overflow", {31'd0, overflow_o}, 32'd0);
    check("rst_underrun", {31'd0, underrun_o}, 32'd0);
    check("rst_abort", {31'd0, abort_o}, 32'd0);
  endtask

  initial begin
    int u0, a0, o0, p0;
    tx_stream[0] = 8'hA5;
    for (int k = 0; k < 16; k++) tx_stream[1+k] = 8'hF0 + 8'(k);
    for (int k = 17; k < 128; k++) tx_stream[k] = 8'($urandom);

    // Reset state
    rst_i = 1'b1;
    wait_cyc(4);
    check_reset_outputs();
    rst_i = 1'b0;
    wait_cyc(Half);

    // 0x3C in, 0xA5 out
    rx_ready_fixed = 1'b0;
    tx_valid_i = 1'b1;
    fr_n = 1; fr_last_bits = 8; fr_hold = 1'b0; fr_bytes[0] = 8'h3C;
    run_frame();
    check("a5_miso_literal", {24'd0, miso_log[0]}, 32'hA5);
    check("3c_rx_valid", {31'd0, rx_valid_o}, 32'd1);
    check("3c_rx_data_literal", {24'd0, rx_data_o}, 32'h3C);
    rx_ready_fixed = 1'b1;
    wait_cyc(4);
    check_counts();

    // Underrun: 0x00 in, 0xFF out
    u0 = cnt_und;
    tx_valid_i = 1'b0;
    fr_bytes[0] = 8'h00;
    run_frame();
    check("underrun_miso_ff", {24'd0, miso_log[0]}, 32'hFF);
    check("underrun_once", cnt_und - u0, 32'd1);
    wait_cyc(4);
    check_counts();

    // Overflow: five bytes with the sink stalled
    o0 = cnt_ovf; p0 = cnt_pop;
    rx_ready_fixed = 1'b0;
    wait_cyc(2);
    fr_n = 5;
    for (int k = 0; k < 5; k++) fr_bytes[k] = 8'(k + 1);
    run_frame();
    check("ovf_pulses_literal", cnt_ovf - o0, OvfLit);
    check("ovf_head_literal", {24'd0, rx_data_o}, 32'h01);
    rx_ready_fixed = 1'b1;
    wait_cyc(12);
    check("ovf_pop_count", cnt_pop - p0, PopLit);
    check("ovf_drained", {31'd0, rx_valid_o}, 32'd0);
    check_counts();

    // Abort after three bits, then 0x81
    a0 = cnt_abt;
    fr_n = 1; fr_last_bits = 3; fr_bytes[0] = 8'hE0;
    run_frame();
    check("abort_once", cnt_abt - a0, 32'd1);
    check("abort_no_rx", {31'd0, rx_valid_o}, 32'd0);
    fr_last_bits = 8; fr_bytes[0] = 8'h81;
    p0 = cnt_pop;
    run_frame();
    wait_cyc(4);
    check("after_abort_pop", cnt_pop - p0, 32'd1);
    check_counts();

    // 16 back-to-back bytes with TX stream 0xF0..0xFF
    tx_valid_i = 1'b1;
    p0 = cnt_pop;
    fr_n = 16;
    for (int k = 0; k < 16; k++) fr_bytes[k] = 8'(k);
    run_frame();
    for (int k = 0; k < 16; k++) check("stream_miso_literal", {24'd0, miso_log[k]}, 32'hF0 + k);
    wait_cyc(4);
    check("stream_pop_count", cnt_pop - p0, 32'd16);
    check_counts();

    // Reset after five bits
    tx_valid_i = 1'b0;
    a0 = cnt_abt;
    fr_n = 1; fr_last_bits = 5; fr_hold = 1'b1; fr_bytes[0] = 8'hC3;
    run_frame();
    rst_i = 1'b1;
    spi_csn_i = 1'b1;
    exp_q.delete();
    wait_cyc(3);
    check_reset_outputs();
    rst_i = 1'b0;
    wait_cyc(2 * Half);
    check("reset_stays_idle", {31'd0, spi_miso_oe_o}, 32'd0);
    check("reset_no_abort", cnt_abt - a0, 32'd0);
    fr_hold = 1'b0; fr_last_bits = 8; fr_bytes[0] = 8'h5A;
    p0 = cnt_pop;
    run_frame();
    wait_cyc(4);
    check("post_reset_pop", cnt_pop - p0, 32'd1);
    check_counts();

    // Random frames with a random sink
    rx_rand = 1'b1;
    for (int f = 0; f < 6; f++) begin
      fr_n = $urandom_range(1, 4);
      for (int k = 0; k < fr_n; k++) fr_bytes[k] = 8'($urandom);
      fr_last_bits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
      tx_valid_i = 1'($urandom_range(0, 1));
      run_frame();
    end
    rx_rand = 1'b0;
    rx_ready_fixed = 1'b1;
    wait_cyc(10);
    check("random_drained", exp_q.size(), 32'd0);
    check_counts();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pms_spi_slave.md
PMS_SPI_SLAVE -- requirements
Module: pms_spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on each SPI input (legal 2..4).
REQ-002 SHALL have parameter RX_FIFO_DEPTH, default 4, RX FIFO entries; power of two; used only when PMS_SPI_SLV_RX_FIFO_EN is defined.
REQ-003 clk_i  input  1  system clock; one clock domain; reset is synchronous and active-high.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 spi_sclk_i  input  1  SPI clock from external master, asynchronous.
REQ-006 spi_csn_i  input  1  chip select, active-low, asynchronous.
REQ-007 spi_mosi_i  input  1  master-out data, asynchronous.
REQ-008 spi_miso_o  output  1  slave-out data.
REQ-009 spi_miso_oe_o  output  1  MISO output enable.
REQ-010 tx_data_i  input  8  next byte to transmit.
REQ-011 tx_valid_i / tx_ready_o  input / output  1 each  TX handshake.
REQ-012 rx_data_o  output  8  received byte.
REQ-013 rx_valid_o / rx_ready_i  output / input  1 each  RX handshake.
REQ-014 overflow_o, underrun_o, abort_o  output  1 each  single-cycle event pulses.

Function
REQ-015 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames, back-to-back bytes within one CS assertion.
REQ-016 SHALL pass sclk, csn, mosi through SYNC_STAGES flops; all logic uses synchronized values and their edge detects (one-cycle rise/fall strobes).
REQ-017 SHALL guarantee correct operation only when each SCLK high and low phase lasts >= SYNC_STAGES+2 clk_i cycles.
REQ-018 FSM states: IDLE, ACTIVE; IDLE->ACTIVE on synchronized csn falling; ACTIVE->IDLE on synchronized csn rising.
REQ-019 Load event (IDLE->ACTIVE transition, or sclk fall after 8th rising edge of a byte): tx shift register loads tx_data_i if tx_valid_i, else 0xFF with underrun_o pulsed in same cycle.
REQ-020 tx_ready_o SHALL be high only in the load-event cycle; transfer occurs when tx_valid_i and tx_ready_o are both high.
REQ-021 On other sclk falls in ACTIVE, tx shift register shifts left by one; spi_miso_o = shift_reg[7].
REQ-022 spi_miso_oe_o SHALL be 1 only in ACTIVE; spi_miso_o SHALL be 0 in IDLE.
REQ-023 On each sclk rise in ACTIVE, rx shift register shifts in synchronized mosi; 3-bit bit counter increments, wrapping 7->0.
REQ-024 On 8th rise, completed byte SHALL be pushed to RX storage in the following cycle; if storage full and no pop in that cycle, byte is dropped and overflow_o pulses.
REQ-025 Simultaneous push and pop on full storage SHALL succeed without overflow.
REQ-026 rx_valid_o high while storage non-empty; rx_data_o shows oldest byte; pop when rx_valid_o and rx_ready_i.
REQ-027 csn rising with bit counter != 0: partial byte discarded, abort_o pulses, counter clears; counter = 0: no abort.
REQ-028 Sclk edges while IDLE SHALL be ignored.

Reset
REQ-029 On rst_i: FSM IDLE, synchronizers sclk=0/csn=1/mosi=0, shift registers 0x00, bit counter 0, RX storage empty.
REQ-030 Output reset values: spi_miso_o=0, spi_miso_oe_o=0, tx_ready_o=0, rx_valid_o=0, rx_data_o=0x00, overflow_o=0, underrun_o=0, abort_o=0.
REQ-031 Reset asserted mid-frame SHALL discard partial data with no abort_o pulse; after release, the block stays IDLE until the next synchronized csn falling edge.

Configuration
REQ-032 Macro PMS_SPI_SLV_RX_FIFO_EN defined: RX storage is an RX_FIFO_DEPTH-entry FIFO with wrap-around pointers; full = RX_FIFO_DEPTH entries.
REQ-033 Macro undefined: RX storage is a single holding register; full = rx_valid_o high; RX_FIFO_DEPTH ignored.

Verification
REQ-034 CS low, tx_data_i=0xA5 valid, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data_o=0x3C with rx_valid_o; no event pulses.
REQ-035 tx_valid_i=0 at CS fall, master sends 0x00 -> MISO all ones (0xFF), underrun_o one pulse, rx_data_o=0x00.
REQ-036 rx_ready_i=0, master sends 5 bytes 0x01..0x05 -> FIFO build: 4 bytes held, overflow_o once, pops return 0x01..0x04; non-FIFO build: 0x01 held, overflow_o four times.
REQ-037 CS deasserted after 3 bits -> abort_o one pulse, no rx_valid_o; next frame 0x81 received correctly.
REQ-038 rx_ready_i=1 constantly, 16 back-to-back bytes 0x00..0x0F with tx stream 0xF0..0xFF -> all bytes received in order, MISO matches, no overflow or underrun.
REQ-039 rst_i asserted after 5 bits of a byte -> outputs at reset values, no abort_o; subsequent full frame 0x5A received correctly.
